// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: schedule constants, FSM state type,
// and the small byte/word helpers used by the forward and inverse steps.
package aes_pkg;

    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam int         NR         = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        REVERSE = 2'd2,
        DONE    = 2'd3
    } ks_state_t;

    // Multiply by x in GF(2^8): the forward round-constant step.
    function automatic logic [7:0] rcon_fwd(input logic [7:0] rc);
        logic [7:0] r;
        if (rc[7]) begin
            r = {rc[6:0], 1'b0} ^ 8'h1b;
        end else begin
            r = {rc[6:0], 1'b0};
        end
        return r;
    endfunction

    // Divide by x in GF(2^8): undoes rcon_fwd, walking 0x36 back to 0x01.
    function automatic logic [7:0] rcon_inv(input logic [7:0] rc);
        logic [7:0] t;
        logic [7:0] r;
        if (rc[0]) begin
            t = rc ^ 8'h1b;
            r = {1'b1, t[7:1]};
        end else begin
            r = {1'b0, rc[7:1]};
        end
        return r;
    endfunction

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table (purely combinational).
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Byte 0x00 occupies the most significant byte of the table.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module sub_word (
    input  logic [31:0] w,
    output logic [31:0] y
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .a (w[8*gi +: 8]),
            .y (y[8*gi +: 8])
        );
    end

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: expands the cipher key forward to the
// round-10 key in a single register, then walks it back one round per
// accepted handshake, presenting round keys 10 down to 0.
module inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    ks_state_t    state_r;
    ks_state_t    state_n;
    logic [127:0] key_r;
    logic [127:0] key_n;
    logic [7:0]   rcon_r;
    logic [7:0]   rcon_n;
    logic [3:0]   round_r;
    logic [3:0]   round_n;
    logic         busy_r;
    logic         valid_r;
    logic         done_r;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  fwd_sub_s;
    logic [31:0]  inv_sub_s;
    logic [31:0]  f0_s, f1_s, f2_s, f3_s;
    logic [31:0]  i0_s, i1_s, i2_s, i3_s;
    logic [127:0] fwd_key_s;
    logic [127:0] inv_key_s;
    logic         hs_s;

    assign w0_s = key_r[127:96];
    assign w1_s = key_r[95:64];
    assign w2_s = key_r[63:32];
    assign w3_s = key_r[31:0];

    // Forward step: next round key from the current one.
    sub_word u_sub_fwd (
        .w (rot_word(w3_s)),
        .y (fwd_sub_s)
    );

    assign f0_s      = w0_s ^ fwd_sub_s ^ {rcon_r, 24'h000000};
    assign f1_s      = w1_s ^ f0_s;
    assign f2_s      = w2_s ^ f1_s;
    assign f3_s      = w3_s ^ f2_s;
    assign fwd_key_s = {f0_s, f1_s, f2_s, f3_s};

    // Inverse step: the previous w3 is recovered first because the S-box
    // input of the forward step was the previous round's w3.
    assign i3_s = w3_s ^ w2_s;
    assign i2_s = w2_s ^ w1_s;
    assign i1_s = w1_s ^ w0_s;

    sub_word u_sub_inv (
        .w (rot_word(i3_s)),
        .y (inv_sub_s)
    );

    assign i0_s      = w0_s ^ inv_sub_s ^ {rcon_r, 24'h000000};
    assign inv_key_s = {i0_s, i1_s, i2_s, i3_s};

    assign hs_s = valid_r & rk_ready;

    // Next-state, key, round-constant and round-counter logic.
    always_comb begin
        state_n = state_r;
        key_n   = key_r;
        rcon_n  = rcon_r;
        round_n = round_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    key_n   = key_in;
                    rcon_n  = RCON_FIRST;
                    round_n = 4'd0;
                    state_n = EXPAND;
                end else begin
                    state_n = IDLE;
                end
            end
            EXPAND: begin
                key_n   = fwd_key_s;
                round_n = round_r + 4'd1;
                if (round_r == 4'(NR - 1)) begin
                    // Keep the last-used constant: the first inverse step needs it.
                    rcon_n  = RCON_LAST;
                    state_n = REVERSE;
                end else begin
                    rcon_n  = rcon_fwd(rcon_r);
                    state_n = EXPAND;
                end
            end
            REVERSE: begin
                if (hs_s) begin
                    if (round_r == 4'd0) begin
                        state_n = DONE;
                    end else begin
                        key_n   = inv_key_s;
                        round_n = round_r - 4'd1;
                        // Round 1 used 0x01; stop there instead of stepping past it.
                        if (round_r == 4'd1) begin
                            rcon_n = rcon_r;
                        end else begin
                            rcon_n = rcon_inv(rcon_r);
                        end
                    end
                end else begin
                    state_n = REVERSE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            key_r   <= 128'd0;
            rcon_r  <= RCON_FIRST;
            round_r <= 4'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            key_r   <= key_n;
            rcon_r  <= rcon_n;
            round_r <= round_n;
            busy_r  <= (state_n == EXPAND) || (state_n == REVERSE);
            valid_r <= (state_n == REVERSE);
            done_r  <= (state_n == DONE);
        end
    end

    assign busy     = busy_r;
    assign rk_valid = valid_r;
    assign done     = done_r;
    assign rk_out   = key_r;
    assign rk_round = round_r;

endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a schedule; sampled only in IDLE.
REQ-005 SHALL have port key_in, input, 128 bits: cipher key; word w0 is in [127:96].
REQ-006 SHALL have port busy, output, 1 bit: high in EXPAND and REVERSE.
REQ-007 SHALL have port rk_valid, output, 1 bit: rk_out and rk_round are valid.
REQ-008 SHALL have port rk_ready, input, 1 bit: consumer accepts the round key.
REQ-009 SHALL have port rk_out, output, 128 bits: current round key.
REQ-010 SHALL have port rk_round, output, 4 bits: round index of rk_out, counting from 10 down to 0.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the round-0 key is accepted.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, REVERSE and DONE.
REQ-013 IDLE: if start=1 in cycle T, SHALL latch key_in, set rcon=0x01 and round=0, and enter EXPAND at T+1.
REQ-014 EXPAND: each cycle SHALL apply the forward step.
- w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}; wi'=wi^w(i-1)' for i=1..3.
- rcon steps by xtime; round increments.
- After 10 cycles (T+1..T+10): key = round-10 key, rcon=0x36, enter REVERSE.
REQ-015 REVERSE: rk_valid SHALL be high from T+11 with rk_out = current key and rk_round = round.
- First output is rk_round=10 at T+11.
REQ-016 While rk_valid=1 and rk_ready=0, rk_out and rk_round SHALL hold stable.
REQ-017 On a handshake with round>0, the next cycle SHALL present round-1 using the inverse step.
- wi'=wi^w(i-1) for i=3,2,1.
- w0'=w0^SubWord(RotWord(w3'))^{rcon,24'h0}.
- rcon steps by inverse xtime: lsb=1 gives ((rcon^0x1b)>>1)|0x80; else rcon>>1.
- rk_valid may stay high back-to-back, giving one key per cycle.
REQ-018 On a handshake with round=0, SHALL enter DONE; in DONE, done=1 and rk_valid=0 for one cycle, then IDLE.
REQ-019 start SHALL be ignored outside IDLE.
- In DONE, start is ignored.
- start in the IDLE cycle after DONE is honoured.
REQ-020 rk_ready SHALL be ignored while rk_valid=0.
REQ-021 The schedule SHALL keep only one 128-bit key register; no round-key storage array.
REQ-022 SubWord SHALL be combinational; no extra latency beyond the stated cycles.

Reset
REQ-023 reset=1 at any clock edge, including mid-EXPAND or mid-REVERSE, SHALL force IDLE.
- Outputs at reset: busy=0, rk_valid=0, done=0, rk_out=0, rk_round=0.
- Internal state at reset: rcon=0x01.
REQ-024 reset SHALL take priority over start and rk_ready in the same cycle.
REQ-025 After reset, the first start SHALL behave as in REQ-013 with no residue of the aborted run.

Structure
REQ-026 Package aes_pkg SHALL hold the following constants and type:
- Constants: RCON_FIRST=8'h01, RCON_LAST=8'h36, NR=10.
- The FSM state enum type.
REQ-027 One sub-module sub_word SHALL be used: 32-bit in, 32-bit out, four instances of the team's existing S-box.
- It is instantiated twice: forward path and inverse path.
REQ-028 The rcon forward and inverse step functions SHALL live in aes_pkg.

Verification
REQ-029 Forward/reverse vector:
- Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c, start at T, rk_ready=1.
- Required: at T+11, rk_round=10 and rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Required: at T+20, rk_round=1 and rk_out=a0fafe1788542cb123a339392a6c7605.
- Required: at T+21, rk_round=0 and rk_out=key_in; done at T+22.
REQ-030 Backpressure:
- Stimulus: same key, rk_ready held 0 for 5 cycles at round 7.
- Required: rk_out and rk_round are stable across those cycles; the full sequence is unchanged.
REQ-031 Reset mid-operation:
- Stimulus: reset during EXPAND cycle 4, then a new start with key 000102030405060708090a0b0c0d0e0f.
- Required: round-10 key 13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 start while busy:
- Stimulus: start pulses during REVERSE.
- Required: no restart; done fires once; a start in the IDLE cycle after DONE begins a new run.
REQ-033 rcon round-trip:
- Required: internal rcon sequence in REVERSE is 36,1b,80,40,20,10,08,04,02,01.
- Required: all-zero key gives round-10 key b4ef5bcb3e92e21123e951cf6f8f188e.
